// File: rtl/conv_loop_counter.sv
// conv_loop_counter
//   Three-level nested loop counter for a convolution engine: tap (inner),
//   window (middle) and channel (outer). One run produces exactly
//   TAPS*WINDOWS*CHANNELS valid beats, then pulses done for one cycle.
//
// Parameters
//   TAPS      kernel taps per window (>=2)
//   WINDOWS   output windows per channel (>=2)
//   CHANNELS  channel passes per run (>=1)
//
// Ports
//   clk       single clock, rising edge
//   reset     asynchronous, active-high reset
//   start     begin a run (sampled in IDLE only)
//   en        advance enable; low holds all counters
//   clear     synchronous abort to IDLE (beats start and any beat)
//   stall     (only with CONV_LOOP_COUNTER_STALL_EN) holds counters in RUN
//   count     current tap index               (registered)
//   cycle     current window index            (registered)
//   channel   current channel index           (registered)
//   valid     live beat this cycle            (combinational)
//   tap_last  valid on the last tap           (combinational)
//   win_last  tap_last on the last window     (combinational)
//   busy      state is RUN                    (registered)
//   done      one-cycle pulse after final beat (registered)
//
// Configuration macro
//   CONV_LOOP_COUNTER_STALL_EN  adds the stall input.

module conv_loop_counter #(
  parameter int unsigned TAPS     = 8,
  parameter int unsigned WINDOWS  = 512,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned TAP_W   = $clog2(TAPS),
  localparam int unsigned WIN_W   = $clog2(WINDOWS),
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  input  logic             clear,
`ifdef CONV_LOOP_COUNTER_STALL_EN
  input  logic             stall,
`endif
  output logic [TAP_W-1:0] count,
  output logic [WIN_W-1:0] cycle,
  output logic [CH_W-1:0]  channel,
  output logic             valid,
  output logic             tap_last,
  output logic             win_last,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [TAP_W-1:0] TapMax = TAP_W'(TAPS - 1);
  localparam logic [WIN_W-1:0] WinMax = WIN_W'(WINDOWS - 1);
  localparam logic [CH_W-1:0]  ChMax  = CH_W'(CHANNELS - 1);

  logic [1:0]       r_state, w_state_d;
  logic [TAP_W-1:0] r_count, w_count_d;
  logic [WIN_W-1:0] r_cycle, w_cycle_d;
  logic [CH_W-1:0]  r_channel, w_channel_d;
  logic             r_busy, r_done;

  logic w_hold;
  logic w_valid;
  logic w_tap_max;
  logic w_win_max;
  logic w_ch_max;

`ifdef CONV_LOOP_COUNTER_STALL_EN
  assign w_hold = stall;
`else
  assign w_hold = 1'b0;
`endif

  assign w_valid   = (r_state == StRun) & en & ~w_hold;
  assign w_tap_max = (r_count == TapMax);
  assign w_win_max = (r_cycle == WinMax);
  assign w_ch_max  = (r_channel == ChMax);

  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_cycle_d   = r_cycle;
    w_channel_d = r_channel;
    if (clear) begin
      w_state_d   = StIdle;
      w_count_d   = '0;
      w_cycle_d   = '0;
      w_channel_d = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            w_state_d   = StRun;
            w_count_d   = '0;
            w_cycle_d   = '0;
            w_channel_d = '0;
          end
        end
        StRun: begin
          if (w_valid) begin
            if (!w_tap_max) begin
              w_count_d = r_count + TAP_W'(1);
            end else begin
              w_count_d = '0;
              if (!w_win_max) begin
                w_cycle_d = r_cycle + WIN_W'(1);
              end else begin
                w_cycle_d = '0;
                if (!w_ch_max) begin
                  w_channel_d = r_channel + CH_W'(1);
                end else begin
                  // Final beat of the run: indices park at zero in DONE.
                  w_channel_d = '0;
                  w_state_d   = StDone;
                end
              end
            end
          end
        end
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_cycle   <= '0;
      r_channel <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_cycle   <= w_cycle_d;
      r_channel <= w_channel_d;
      // Status flags track the next state so they are flop outputs.
      r_busy    <= (w_state_d == StRun);
      r_done    <= (w_state_d == StDone);
    end
  end

  assign count    = r_count;
  assign cycle    = r_cycle;
  assign channel  = r_channel;
  assign valid    = w_valid;
  assign tap_last = w_valid & w_tap_max;
  assign win_last = w_valid & w_tap_max & w_win_max;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/conv_loop_counter.md
CONV_LOOP_COUNTER -- requirements
Module: conv_loop_counter

Interface
REQ-001 SHALL have parameter TAPS, default 8: kernel taps per window (>=2).
REQ-002 SHALL have parameter WINDOWS, default 512: output windows per channel (>=2).
REQ-003 SHALL have parameter CHANNELS, default 4: channel passes per run (>=1).
REQ-004 SHALL derive TAP_W=$clog2(TAPS), WIN_W=$clog2(WINDOWS) and CH_W=max(1,$clog2(CHANNELS)) as localparams.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begin a run, sampled in IDLE only.
REQ-008 SHALL have port en, input, 1 bit: advance enable; low holds all counters.
REQ-009 SHALL have port clear, input, 1 bit: synchronous abort to IDLE.
REQ-010 SHALL have port count, output, TAP_W bits: current tap index.
REQ-011 SHALL have port cycle, output, WIN_W bits: current window index.
REQ-012 SHALL have port channel, output, CH_W bits: current channel index.
REQ-013 SHALL have port valid, output, 1 bit: high when count/cycle/channel describe a live beat.
REQ-014 SHALL have port tap_last, output, 1 bit: valid & count==TAPS-1.
REQ-015 SHALL have port win_last, output, 1 bit: tap_last & cycle==WINDOWS-1.
REQ-016 SHALL have port busy, output, 1 bit: state is RUN.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse after the final beat.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE.
REQ-019 In IDLE, start=1 (with clear=0) SHALL move to RUN with count, cycle and channel set to 0.
REQ-020 In RUN, valid SHALL equal en (AND NOT stall when the stall feature is compiled in).
REQ-021 On each valid beat, count SHALL increment by 1.
REQ-022 On a valid beat with count==TAPS-1, count SHALL wrap to 0 and cycle SHALL increment.
REQ-023 On a valid beat with count==TAPS-1 and cycle==WINDOWS-1, cycle SHALL wrap to 0 and channel SHALL increment.
REQ-024 On a valid beat with all three indices at maximum, the block SHALL enter DONE and hold indices at 0.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-026 In RUN with valid=0, all counters SHALL hold; en low SHALL NOT clear them.
REQ-027 clear=1 in any state SHALL force IDLE and zero all counters next cycle; clear SHALL beat start and any beat.
REQ-028 start in RUN or DONE SHALL be ignored.
REQ-029 A run SHALL consist of exactly TAPS*WINDOWS*CHANNELS valid beats.
REQ-030 valid, tap_last and win_last SHALL be combinational from state and inputs; all other outputs SHALL be registered.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, count=0, cycle=0, channel=0 and done=0; valid, busy, tap_last and win_last SHALL then read 0.
REQ-032 reset asserted mid-run SHALL discard the run; the first beat after release requires a new start.

Configuration
REQ-033 Macro CONV_LOOP_COUNTER_STALL_EN, when defined, SHALL add input port stall (1 bit); stall=1 in RUN SHALL force valid=0 and hold counters, and SHALL NOT affect clear or reset.
REQ-034 Without CONV_LOOP_COUNTER_STALL_EN, the stall port SHALL be absent and valid SHALL equal (state==RUN) & en.

Verification (TAPS=2, WINDOWS=3, CHANNELS=2 unless stated)
REQ-035 start pulse, en=1 held -> 12 valid beats in the (channel,cycle,count) order 000,001,010,...,121; done=1 on the cycle after the beat at 121; busy low after that cycle.
REQ-036 en toggled 1/0 every cycle -> counters hold on en=0 cycles; done still arrives after 12 valid beats (about 24 cycles).
REQ-037 clear=1 at beat 5 together with start=1 -> IDLE next cycle with counters 0 and no done; a later start restarts from 000.
REQ-038 reset asserted asynchronously mid-run (between edges) -> outputs zero immediately; start during RUN is ignored (checked separately).
REQ-039 With CONV_LOOP_COUNTER_STALL_EN defined, en=1 and stall=1 for 3 cycles at index 011 -> valid=0 and index held at 011 for 3 cycles, then continues to 020.
REQ-040 Default parameters (8/512/4), en=1 -> tap_last every 8th beat; win_last at beats 4096, 8192, 12288 and 16384; done after beat 16384.
